// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//
// Shared definitions for the FFT result path:
//   FFT_N / FFT_ADDR_W / FFT_DATA_W : transform size, RAM index width and
//                                     width of each Q16.16 real/imag word
//   unload_state_e                  : states of the result unloader FSM
//   bitrev()                        : index bit reversal, shared with
//                                     address_generator
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_N      = 1024;
  localparam int FFT_ADDR_W = 10;
  localparam int FFT_DATA_W = 32;

  // Unload sequence for one point: ADDR -> CAPT -> EMIT_RE -> EMIT_IM.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_CAPT    = 3'd2,
    ST_EMIT_RE = 3'd3,
    ST_EMIT_IM = 3'd4,
    ST_DONE    = 3'd5
  } unload_state_e;

  // Reverse the bit order of a RAM index: result[k] = v[FFT_ADDR_W-1-k].
  function automatic logic [FFT_ADDR_W-1:0] bitrev(input logic [FFT_ADDR_W-1:0] v);
    logic [FFT_ADDR_W-1:0] r;
    r = '0;
    for (int k = 0; k < FFT_ADDR_W; k++) begin
      r[k] = v[FFT_ADDR_W-1-k];
    end
    return r;
  endfunction

endpackage : fft_pkg

// File: rtl/fft_bitrev_counter.sv
// ---------------------------------------------------------------------------
// fft_bitrev_counter
//
// Point counter j for the result unloader, plus the RAM index derived from it.
// The counter saturates at N-1 (it never wraps); the unloader stops there.
//
// Build option:
//   FFT_UNLOAD_BITREV_EN defined   : o_index = bit-reversed j (natural
//                                    frequency order on the stream)
//   FFT_UNLOAD_BITREV_EN undefined : o_index = j (RAM already reordered)
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   i_clear     in   force j to 0 (start of an unload)
//   i_incr      in   advance j by one (ignored at terminal count)
//   o_index     out  RAM read index derived from j
//   o_terminal  out  j == N-1
// ---------------------------------------------------------------------------
module fft_bitrev_counter
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int ADDR_W = FFT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_incr,
  output logic [ADDR_W-1:0] o_index,
  output logic              o_terminal
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(N - 1);

  logic [ADDR_W-1:0] r_j;
  logic [ADDR_W-1:0] w_index;
  logic              w_terminal;

  assign w_terminal = (r_j == LP_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_j <= '0;
    end else if (i_clear) begin
      r_j <= '0;
    end else if (i_incr && !w_terminal) begin
      r_j <= r_j + 1'b1;
    end
  end

`ifdef FFT_UNLOAD_BITREV_EN
  // Pure wiring: index bit k comes from counter bit ADDR_W-1-k.
  for (genvar k = 0; k < ADDR_W; k++) begin : g_rev
    assign w_index[k] = r_j[ADDR_W-1-k];
  end
`else
  assign w_index = r_j;
`endif

  assign o_index    = w_index;
  assign o_terminal = w_terminal;

endmodule : fft_bitrev_counter

// File: rtl/fft_result_unloader.sv
// ---------------------------------------------------------------------------
// fft_result_unloader
//
// Streams the FFT result out of fft_ram after the butterfly stages finish.
// For every point j = 0..N-1 the block addresses the RAM through its external
// index port, captures the real/imag pair one cycle later, and emits the real
// word followed by the imag word on a valid/ready stream. out_last flags the
// imag word of the final point; done pulses once the last word is accepted.
//
// Build option (see fft_bitrev_counter):
//   FFT_UNLOAD_BITREV_EN : read the RAM in bit-reversed index order
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-low reset
//   start           in   one-cycle pulse, FFT complete (ignored while busy)
//   busy            out  high from accepted start until done
//   done            out  one-cycle pulse after the last word is accepted
//   scan            out  selects externalIndexA in fft_ram's index mux
//   externalIndexA  out  RAM read index
//   A_real_o        in   RAM real read data (one-cycle latency)
//   A_imag_o        in   RAM imag read data (one-cycle latency)
//   out_data        out  stream word
//   out_valid       out  stream word valid
//   out_ready       in   consumer accepts word
//   out_last        out  marks the imag word of the final point
//
// Every output is a flop (or wiring from the counter flop); out_ready only
// steers next-state logic, never an output directly.
// ---------------------------------------------------------------------------
module fft_result_unloader
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int ADDR_W = FFT_ADDR_W,
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              scan,
  output logic [ADDR_W-1:0] externalIndexA,
  input  logic [DATA_W-1:0] A_real_o,
  input  logic [DATA_W-1:0] A_imag_o,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  unload_state_e     r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_scan;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic [DATA_W-1:0] r_hold_im;

  logic              w_clear;
  logic              w_incr;
  logic              w_terminal;
  logic [ADDR_W-1:0] w_index;

  // Counter control: clear on an accepted start, advance on the imag handshake.
  assign w_clear = (r_state == ST_IDLE) && start;
  assign w_incr  = (r_state == ST_EMIT_IM) && out_ready && !w_terminal;

  fft_bitrev_counter #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_incr     (w_incr),
    .o_index    (w_index),
    .o_terminal (w_terminal)
  );

  // Single FSM process; outputs are updated on the same edge as the state so
  // they always line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_scan      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      // NOTE: the hold register is a plain datapath flop, but it is reset
      // anyway so no X can ever reach out_data after reset.
      r_hold_im   <= '0;
    end else begin
      // done is a single-cycle pulse unless re-asserted below.
      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ADDR;
            r_busy  <= 1'b1;
            r_scan  <= 1'b1;
          end
        end

        // Index is already on externalIndexA; the RAM samples it this edge.
        ST_ADDR: begin
          r_state <= ST_CAPT;
        end

        // Read data is valid now: the real word goes straight to the
        // stream register, the imag word waits in the hold register.
        ST_CAPT: begin
          r_out_data  <= A_real_o;
          r_hold_im   <= A_imag_o;
          r_out_valid <= 1'b1;
          r_state     <= ST_EMIT_RE;
        end

        ST_EMIT_RE: begin
          if (out_ready) begin
            r_out_data <= r_hold_im;
            r_out_last <= w_terminal;
            r_state    <= ST_EMIT_IM;
          end
        end

        ST_EMIT_IM: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_terminal) begin
              r_state <= ST_DONE;
              r_scan  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ADDR;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_scan      <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign scan           = r_scan;
  assign externalIndexA = w_index;
  assign out_data       = r_out_data;
  assign out_valid      = r_out_valid;
  assign out_last       = r_out_last;

endmodule : fft_result_unloader

// File: tb/tb_fft_result_unloader.sv
// ---------------------------------------------------------------------------
// tb_fft_result_unloader
//
// Drives fft_result_unloader against a behavioural one-cycle-latency RAM and
// compares the stream against a reference built from the RAM contents and
// the expected read order (bit-reversed when FFT_UNLOAD_BITREV_EN is set).
// ---------------------------------------------------------------------------
module tb_fft_result_unloader;

  localparam int N       = 1024;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int WORDS   = 2 * N;
  localparam int BUDGET  = 20000;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              scan;
  logic [ADDR_W-1:0] externalIndexA;
  logic [DATA_W-1:0] A_real_o;
  logic [DATA_W-1:0] A_imag_o;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  logic [DATA_W-1:0] mem_re [0:N-1];
  logic [DATA_W-1:0] mem_im [0:N-1];
  logic [DATA_W-1:0] got [0:3];

  int n_pass;
  int n_fail;
  int n_total;

  fft_result_unloader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .scan           (scan),
    .externalIndexA (externalIndexA),
    .A_real_o       (A_real_o),
    .A_imag_o       (A_imag_o),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fft_ram read port: data appears one cycle after the index is sampled.
  always @(posedge clk) begin
    A_real_o <= mem_re[externalIndexA];
    A_imag_o <= mem_im[externalIndexA];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Which RAM location holds stream point p.
  function automatic int ref_index(input int p);
`ifdef FFT_UNLOAD_BITREV_EN
    int r;
    int v;
    r = 0;
    v = p;
    for (int k = 0; k < ADDR_W; k++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
`else
    return p;
`endif
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    int idx;
    idx = ref_index(w / 2);
    return (w % 2 == 0) ? mem_re[idx] : mem_im[idx];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy),           32'd0);
    check({tag, "_done"},  32'(done),           32'd0);
    check({tag, "_scan"},  32'(scan),           32'd0);
    check({tag, "_index"}, 32'(externalIndexA), 32'd0);
    check({tag, "_data"},  out_data,            32'd0);
    check({tag, "_valid"}, 32'(out_valid),      32'd0);
    check({tag, "_last"},  32'(out_last),       32'd0);
  endtask

  // One unload: pulse start, then per cycle (sampled at negedge) choose
  // out_ready, score every accepted word and every stalled cycle.
  task automatic run_unload(input int low_pct, input int busy_start_pt,
                            input int reset_pt, input bit check_timing);
    int w;
    int c;
    int dones;
    int done_cycle;
    bit fin;
    bit pulsed;
    bit stall_prev;
    logic [31:0]       prev_data;
    logic              prev_last;
    logic [ADDR_W-1:0] prev_idx;

    w = 0; c = 0; dones = 0; done_cycle = -1;
    fin = 1'b0; pulsed = 1'b0; stall_prev = 1'b0;
    prev_data = '0; prev_last = 1'b0; prev_idx = '0;

    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;

    while (!fin && c < BUDGET) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (busy_start_pt >= 0 && !pulsed && w == 2 * busy_start_pt) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end

      if (reset_pt >= 0 && w == 2 * reset_pt) begin
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        fin = 1'b1;
      end else begin
        if (c == 1) check("busy_after_start", 32'(busy), 32'd1);
        if (stall_prev) begin
          check("stall_valid", 32'(out_valid),      32'd1);
          check("stall_data",  out_data,            prev_data);
          check("stall_last",  32'(out_last),       32'(prev_last));
          check("stall_index", 32'(externalIndexA), 32'(prev_idx));
        end
        if (done) begin
          dones++;
          if (done_cycle < 0) done_cycle = c;
        end

        out_ready = ($urandom_range(99) >= low_pct);

        if (w >= WORDS) begin
          check("no_word_after_last", 32'(out_valid), 32'd0);
        end else if (out_valid && out_ready) begin
          check("word_data", out_data, ref_word(w));
          check("word_last", 32'(out_last), 32'(w == WORDS - 1));
          if (w < 4) got[w] = out_data;
          w++;
        end

        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_idx   = externalIndexA;

        // Keep watching a few cycles after done for a spurious second pulse.
        if (done_cycle >= 0 && c >= done_cycle + 8) fin = 1'b1;
      end
    end

    check("run_finished", 32'(fin), 32'd1);
    if (reset_pt < 0) begin
      check("word_count", 32'(w),     32'(WORDS));
      check("done_count", 32'(dones), 32'd1);
      check("busy_idle",  32'(busy),  32'd0);
      if (check_timing) check("done_cycle", 32'(done_cycle), 32'(4 * N + 1));
    end
    out_ready = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      mem_re[i] = 32'(i);
      mem_im[i] = ~32'(i);
    end

    // Power-on reset values, during and after reset.
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // Full-rate unload with exact done timing.
    run_unload(0, -1, -1, 1'b1);
`ifdef FFT_UNLOAD_BITREV_EN
    check("nat_word0", got[0], 32'h00000000);
    check("nat_word1", got[1], 32'hFFFFFFFF);
    check("nat_word2", got[2], 32'h00000200);
    check("nat_word3", got[3], 32'hFFFFFDFF);
`else
    check("nat_word0", got[0], 32'h00000000);
    check("nat_word1", got[1], 32'hFFFFFFFF);
    check("nat_word2", got[2], 32'h00000001);
    check("nat_word3", got[3], 32'hFFFFFFFE);
`endif

    // Random backpressure, ~30% of cycles not ready.
    run_unload(30, -1, -1, 1'b0);

    // start pulsed again while busy at point 100 must be ignored.
    run_unload(0, 100, -1, 1'b1);

    // Reset at point 300, then a fresh unload from point 0.
    run_unload(0, -1, 300, 1'b0);
    @(negedge clk);
    check_reset_outputs("held_reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_unload(20, -1, -1, 1'b0);
    check("restart_word0", got[0], 32'h00000000);

    // Random RAM contents under backpressure.
    for (int i = 0; i < N; i++) begin
      mem_re[i] = $urandom;
      mem_im[i] = $urandom;
    end
    run_unload(30, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_fft_result_unloader

// File: doc/fft_result_unloader.md
# fft_result_unloader

Streams the 1024-point FFT result out of `fft_ram` once the butterfly stages have finished. It walks all points in bit-reversed address order to undo the decimation ordering. For each point it presents real then imaginary words on a valid/ready stream. The block sits between `fft_ram`'s external index port (it drives `externalIndexA` and `scan`) and the downstream result consumer, and replaces the software read-out loop used in bench flows.

## Interface
- `N`, 1024: number of complex points; power of two
- `ADDR_W`, 10: log2(N), width of RAM index
- `DATA_W`, 32: width of each real/imag word (Q16.16 signed)

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse: FFT complete, begin unload
- `busy`  out  1  high from accepted start until done
- `done`  out  1  one-cycle pulse after last word accepted
- `scan`  out  1  to `fft_ram` index mux; selects `externalIndexA`
- `externalIndexA`  out  ADDR_W  RAM read index
- `A_real_o`  in  DATA_W  RAM real read data
- `A_imag_o`  in  DATA_W  RAM imag read data
- `out_data`  out  DATA_W  stream word
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  consumer accepts word
- `out_last`  out  1  marks imag word of final point

## Operation
- States: IDLE, ADDR, CAPT, EMIT_RE, EMIT_IM, DONE.
- IDLE: `start` moves the FSM to ADDR and clears the point counter `j`. `start` in any other state is ignored.
- ADDR: drive `externalIndexA` = bitrev(`j`), with `scan`=1. Go to CAPT.
- CAPT: register `A_real_o`/`A_imag_o` into the hold pair (RAM read latency is one cycle). Go to EMIT_RE.
- EMIT_RE: `out_data`=held real, `out_valid`=1. On `out_ready`, go to EMIT_IM.
- EMIT_IM: `out_data`=held imag, `out_valid`=1, `out_last`=(`j`==N-1).
  - On `out_ready` with `j`<N-1: increment `j` and go to ADDR.
  - On `out_ready` with `j`==N-1: go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `j` is ADDR_W bits and never wraps. The last point terminates the unload.
- bitrev: `externalIndexA[k]` = `j[ADDR_W-1-k]`.
- `busy`=1 in every state except IDLE. `scan`=1 from ADDR through EMIT_IM.
- Reset in the middle of an unload: return to IDLE immediately and drop the partial stream. No `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `scan`=0, `externalIndexA`=0, `out_data`=0, `out_valid`=0, `out_last`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `out_ready` to any output.
- Per point: 4 cycles minimum (ADDR, CAPT, RE, IM) with `out_ready` held high.
- Full unload: 4N cycles from the cycle after `start` to the last handshake. `done` asserts on the following cycle.
- While `out_valid`=1 and `out_ready`=0: `out_data` and `out_last` stay stable, and the RAM index is held.
- `out_valid` never drops without a handshake, except on reset.

## Configuration
- `FFT_UNLOAD_BITREV_EN` defined: `externalIndexA` = bitrev(`j`), giving natural frequency order on the stream.
- Not defined: `externalIndexA` = `j`. Use this for RAM contents that are already reordered.
- Cycle counts are identical in both cases.

## Structure
- Shared `fft_pkg` holds:
  - constants `FFT_N`, `FFT_ADDR_W`, `FFT_DATA_W`
  - the unload state enum
  - a `bitrev` function, also usable by `address_generator`
- Sub-module `fft_bitrev_counter` contains the `j` counter, its clear/increment/terminal-count logic, and the macro-selected reversed or natural index output.

## Test plan
- **Natural-order unload:** preload RAM point i with real=i, imag=~i. Pulse `start` with `out_ready`=1.
  - Words 0..3 = 0x00000000, 0xFFFFFFFF, 0x00000200, 0xFFFFFDFF (point 512).
  - 2048 words in total, with `out_last` only on word 2047.
  - `done` asserts exactly 4097 cycles after `start`.
- **Random backpressure:** toggle `out_ready` at 30% low. The stream matches the first test word for word, and `out_data` holds stable in every stalled cycle.
- **Start while busy:** pulse `start` at point 100. The stream is unaffected and only one `done` is produced.
- **Reset mid-unload:** assert `rst` low at point 300. All outputs take reset values on the next sample. A new `start` restarts from point 0 with word 0 = 0x00000000.
- **Macro undefined:** with the same preload, words 2..3 = 0x00000001, 0xFFFFFFFE (point 1).
